vc_credit_sender: RTL and testbench
===================================

// Module: vc_credit_sender
// PURPOSE
//   Upstream transmitter for the valid/credit link into vc_vr_converter.
//   Accepts beats on a valid/ready interface and forwards each one as a single-cycle
//   valid pulse with registered data. It keeps one credit per free slot in the downstream
//   FIFO, so it never sends more beats than the FIFO can hold.
//   Downstream returns one credit pulse per FIFO pop.
// PARAMETERS
//   WIDTH       8    payload width in bits
//   CREDIT_NUM  10   initial credits; must equal downstream FIFO DEPTH; >= 1
//   CNT_W (localparam) = $clog2(CREDIT_NUM + 1), width of the credit counter
// PORTS
//   clk_i          in   1        clock, rising edge
//   rstn_i         in   1        reset, asynchronous, active-low
//   up_valid_i     in   1        upstream beat valid
//   up_data_i      in   WIDTH    upstream beat payload
//   up_ready_o     out  1        sender can accept a beat this cycle
//   down_valid_o   out  1        single-cycle pulse: one beat on down_data_o
//   down_data_o    out  WIDTH    payload; valid only while down_valid_o = 1
//   down_credit_i  in   1        one credit returned per cycle it is high
//   credit_cnt_o   out  CNT_W    credits currently held
//   credit_err_o   out  1        sticky: a credit was returned while the counter was full
// BEHAVIOUR
// - Reset (async, rstn_i low), all values take effect immediately:
//   credit_cnt = CREDIT_NUM, down_valid_o = 0, down_data_o = 0, credit_err_o = 0.
//   Any beat or credit in flight when reset asserts is dropped.
// - up_ready_o = (credit_cnt != 0).
//   It is decoded from the registered counter only, so there is no combinational
//   path from down_credit_i or up_valid_i to up_ready_o.
// - Send: fires when up_valid_i & up_ready_o are both high on a clock edge.
//   Next cycle: down_valid_o = 1, down_data_o = the up_data_i value captured at that edge.
//   Latency is exactly 1 cycle, up_* to down_*.
// - No send in a cycle -> down_valid_o = 0 next cycle; down_data_o holds its last value.
// - No backpressure on the down side: every down_valid_o pulse is consumed.
//   Throughput is 1 beat/cycle while credits remain.
// - Credit counter update, per cycle:
//   send & !credit   -> cnt - 1
//   !send & credit   -> cnt + 1; if cnt == CREDIT_NUM: cnt holds (saturates), credit_err_o <= 1
//   send & credit    -> cnt unchanged (legal at any cnt >= 1, including CREDIT_NUM)
//   neither          -> cnt unchanged
// - At cnt == 0, a credit arriving in the same cycle does not enable a send that cycle.
//   up_ready_o rises the following cycle.
// - credit_err_o stays at 1 until reset. Once set, it has no other effect on operation.
// - Invariant: beats sent - credits returned <= CREDIT_NUM at all times.
//   credit_cnt_o never exceeds CREDIT_NUM and never wraps below 0.
// - up_data_i is sampled only on a send edge. Values while up_ready_o = 0 are ignored.
// TESTING
// 1. Reset, then idle 5 cycles.
//    -> credit_cnt_o = 10, up_ready_o = 1, down_valid_o = 0, credit_err_o = 0.
// 2. Hold up_valid_i high with data 0x01..0x0C, no credits returned.
//    -> 10 down_valid_o pulses carrying 0x01..0x0A, each 1 cycle after its send.
//    -> up_ready_o = 0 after the 10th send; credit_cnt_o = 0; 0x0B is held off.
// 3. From cnt = 0 with up_valid_i high, pulse down_credit_i for 1 cycle.
//    -> up_ready_o = 1 the next cycle; 0x0B is sent; cnt returns to 0.
// 4. At cnt = 3, send and return a credit in the same cycle, for 4 cycles.
//    -> cnt stays 3; 4 pulses come out back-to-back.
// 5. At cnt = 10 with no send, pulse down_credit_i.
//    -> cnt stays 10; credit_err_o = 1 and stays 1 through 20 more normal cycles.
// 6. Assert rstn_i mid-burst, between clock edges (cnt = 4, down_valid_o = 1).
//    -> outputs go to reset values at once, with no clock edge needed.
//    -> after release, cnt = 10 and sends resume normally.

Source files
------------

// File: rtl/vc_credit_sender.sv
// Credit-based upstream sender: forwards accepted valid/ready beats as one-cycle
// valid pulses and never has more beats in flight than the downstream FIFO can hold.
module vc_credit_sender #(
  parameter  int WIDTH      = 8,
  parameter  int CREDIT_NUM = 10,
  localparam int CNT_W      = $clog2(CREDIT_NUM + 1)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             up_ready_o,
  output logic             down_valid_o,
  output logic [WIDTH-1:0] down_data_o,
  input  logic             down_credit_i,
  output logic [CNT_W-1:0] credit_cnt_o,
  output logic             credit_err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDIT_NUM);

  logic [CNT_W-1:0] credit_cnt_q, credit_cnt_d;
  logic             down_valid_q, down_valid_d;
  logic [WIDTH-1:0] down_data_q, down_data_d;
  logic             credit_err_q, credit_err_d;
  logic             send;

  // Handshake: a beat transfers on any rising edge where up_valid_i and up_ready_o
  // are both high; up_valid_i may rise or fall freely, and up_ready_o depends only
  // on the registered credit count, never on this cycle's inputs.
  assign up_ready_o = (credit_cnt_q != '0);
  assign send       = up_valid_i & up_ready_o;

  always_comb begin
    credit_cnt_d = credit_cnt_q;
    credit_err_d = credit_err_q;
    down_valid_d = send;
    down_data_d  = down_data_q;
    if (send) begin
      down_data_d = up_data_i;
    end
    case ({send, down_credit_i})
      2'b10: credit_cnt_d = credit_cnt_q - 1'b1;
      2'b01: begin
        // A credit with the counter already full means the far side over-returned.
        if (credit_cnt_q == CNT_MAX) begin
          credit_err_d = 1'b1;
        end else begin
          credit_cnt_d = credit_cnt_q + 1'b1;
        end
      end
      default: credit_cnt_d = credit_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      credit_cnt_q <= CNT_MAX;
      down_valid_q <= 1'b0;
      down_data_q  <= '0;
      credit_err_q <= 1'b0;
    end else begin
      credit_cnt_q <= credit_cnt_d;
      down_valid_q <= down_valid_d;
      down_data_q  <= down_data_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign down_valid_o = down_valid_q;
  assign down_data_o  = down_data_q;
  assign credit_cnt_o = credit_cnt_q;
  assign credit_err_o = credit_err_q;

endmodule

// File: tb/tb_vc_credit_sender.sv
// Randomized bench for vc_credit_sender against an outstanding-beat model with an
// expected-data queue.
module tb_vc_credit_sender;
  localparam int WIDTH      = 8;
  localparam int CREDIT_NUM = 10;
  localparam int CNT_W      = $clog2(CREDIT_NUM + 1);

  logic             clk_i;
  logic             rstn_i;
  logic             up_valid_i;
  logic [WIDTH-1:0] up_data_i;
  logic             up_ready_o;
  logic             down_valid_o;
  logic [WIDTH-1:0] down_data_o;
  logic             down_credit_i;
  logic [CNT_W-1:0] credit_cnt_o;
  logic             credit_err_o;

  vc_credit_sender #(.WIDTH(WIDTH), .CREDIT_NUM(CREDIT_NUM)) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .up_valid_i    (up_valid_i),
    .up_data_i     (up_data_i),
    .up_ready_o    (up_ready_o),
    .down_valid_o  (down_valid_o),
    .down_data_o   (down_data_o),
    .down_credit_i (down_credit_i),
    .credit_cnt_o  (credit_cnt_o),
    .credit_err_o  (credit_err_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // scoreboard and reference model
  logic [WIDTH-1:0] exp_q[$];
  int               checks = 0;
  int               errors = 0;
  int               outstanding;
  logic             m_err;
  logic             m_dv;
  logic [WIDTH-1:0] m_last;
  logic             last_send;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_cnt();
    return CREDIT_NUM - outstanding;
  endfunction

  task automatic model_reset();
    outstanding = 0;
    m_err       = 1'b0;
    m_dv        = 1'b0;
    m_last      = '0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    check_val("credit_cnt", 32'(credit_cnt_o), 32'(m_cnt()));
    check_val("up_ready", 32'(up_ready_o), 32'(m_cnt() != 0));
    check_val("down_valid", 32'(down_valid_o), 32'(m_dv));
    check_val("credit_err", 32'(credit_err_o), 32'(m_err));
    if (m_dv && exp_q.size() > 0) m_last = exp_q.pop_front();
    check_val("down_data", 32'(down_data_o), 32'(m_last));
  endtask

  // driver: one clock cycle with the given inputs, entered and left at posedge+1
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic c);
    int pre;
    up_valid_i    = v;
    up_data_i     = d;
    down_credit_i = c;
    @(negedge clk_i);
    check_outputs();
    last_send = v && (m_cnt() != 0);
    pre = outstanding;
    if (last_send) exp_q.push_back(d);
    if (c && !last_send && pre == 0) m_err = 1'b1;
    else outstanding = pre + (last_send ? 1 : 0) - (c ? 1 : 0);
    m_dv = last_send;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] idx;
    up_valid_i    = 1'b0;
    up_data_i     = '0;
    down_credit_i = 1'b0;
    rstn_i        = 1'b0;
    model_reset();
    #12;
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;

    // idle after reset
    for (int i = 0; i < 5; i++) cycle(1'b0, WIDTH'(8'hA5), 1'b0);

    // fill all credits, then 0x0B is held off
    idx = 8'h01;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, idx, 1'b0);
      if (last_send) idx++;
    end
    check_val("held_data", 32'(idx), 32'h0B);

    // credit at cnt=0 does not enable a same-cycle send; next cycle sends 0x0B
    cycle(1'b1, idx, 1'b1);
    check_val("no_send_at_zero", 32'(last_send), 32'h0);
    cycle(1'b1, idx, 1'b0);
    check_val("send_0b", 32'(last_send), 32'h1);
    cycle(1'b0, '0, 1'b0);

    // reach cnt=3, then send+credit together for 4 cycles
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, WIDTH'($urandom_range(0, 255)), 1'b1);
    cycle(1'b0, '0, 1'b0);
    check_val("cnt_steady_3", 32'(credit_cnt_o), 32'd3);

    // return to full, then over-return a credit
    for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 20; i++)
      cycle(1'(($urandom_range(0, 1))), WIDTH'($urandom_range(0, 255)), (outstanding > 0) ? 1'($urandom_range(0, 1)) : 1'b0);
    check_val("err_sticky", 32'(credit_err_o), 32'h1);

    // reach full, send 6 beats, then reset between edges
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, (outstanding > 0) ? 1'b1 : 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, WIDTH'(8'h40 + i), 1'b0);
    check_val("pre_rst_cnt", 32'(credit_cnt_o), 32'd4);
    check_val("pre_rst_dv", 32'(down_valid_o), 32'h1);
    #2;
    rstn_i = 1'b0;
    #1;
    model_reset();
    check_outputs();
    up_valid_i    = 1'b0;
    down_credit_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(8'h60 + i), 1'b0);

    // random traffic, credits mostly legal with occasional over-returns
    for (int i = 0; i < 400; i++) begin
      logic c;
      c = (outstanding > 0) ? 1'($urandom_range(0, 2) != 0) : 1'($urandom_range(0, 19) == 0);
      cycle(1'($urandom_range(0, 3) != 0), WIDTH'($urandom_range(0, 255)), c);
    end
    cycle(1'b0, '0, 1'b0);
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
